// File: rtl/dma_pkg.sv
// Shared types and constants for the multichannel AHB DMA engine.
package dma_pkg;

   // Manager-port transfer sequencer states
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD_A = 3'd1,
      ST_RD_D = 3'd2,
      ST_WR_A = 3'd3,
      ST_WR_D = 3'd4
   } dma_state_e;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;

   // Per-channel register offsets and the global status register
   localparam logic [3:0] OFF_SRC     = 4'h0;
   localparam logic [3:0] OFF_DST     = 4'h4;
   localparam logic [3:0] OFF_LEN     = 4'h8;
   localparam logic [3:0] OFF_CTRL    = 4'hC;
   localparam logic [8:0] ADDR_STATUS = 9'h100;

   localparam int unsigned CTRL_EN      = 0;
   localparam int unsigned CTRL_SRC_INC = 1;
   localparam int unsigned CTRL_DST_INC = 2;
   localparam int unsigned CTRL_IE      = 3;
   localparam int unsigned CTRL_BUSY    = 8;
   localparam int unsigned CTRL_DONE    = 9;
   localparam int unsigned CTRL_ERR     = 10;

   // Per-channel control/status flags
   typedef struct packed {
      logic err;
      logic done;
      logic busy;
      logic ie;
      logic dst_inc;
      logic src_inc;
      logic en;
   } ch_flags_t;

endpackage

// File: rtl/dma_rr_arbiter.sv
// Round-robin channel picker: first requester after the last grant wins.
module dma_rr_arbiter #(
   parameter int unsigned N    = 4,
   parameter int unsigned IdxW = 2
) (
   input  logic [N-1:0]    req,
   input  logic [IdxW-1:0] last,
   output logic [N-1:0]    gnt,
   output logic [IdxW-1:0] idx,
   output logic            valid
);

   int unsigned     cand;
   logic [IdxW-1:0] cand_idx;

   // Scan N candidates starting one past the previous grant
   always_comb begin
      gnt      = '0;
      idx      = '0;
      valid    = 1'b0;
      cand     = '0;
      cand_idx = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         cand     = (32'(last) + i) % N;
         cand_idx = IdxW'(cand);
         if (!valid && req[cand_idx]) begin
            valid         = 1'b1;
            gnt[cand_idx] = 1'b1;
            idx           = cand_idx;
         end
      end
   end

endmodule

// File: rtl/dma_ahb_multichannel.sv
// Multichannel memory-to-memory DMA: AHB-lite register port, AHB-lite manager port.
module dma_ahb_multichannel
   import dma_pkg::*;
#(
   parameter int unsigned ChannelCount = 4,
   parameter int unsigned AddressWidth = 32,
   parameter int unsigned DataWidth    = 32,
   parameter int unsigned LenWidth     = 16
) (
   input  logic                    HCLK,
   input  logic                    HRESETn,
   input  logic                    S_HSEL,
   input  logic [AddressWidth-1:0] S_HADDR,
   input  logic [1:0]              S_HTRANS,
   input  logic                    S_HWRITE,
   input  logic [2:0]              S_HSIZE,
   input  logic [DataWidth-1:0]    S_HWDATA,
   input  logic                    S_HREADYin,
   output logic [DataWidth-1:0]    S_HRDATA,
   output logic                    S_HREADYout,
   output logic                    S_HRESP,
   output logic [AddressWidth-1:0] M_HADDR,
   output logic [1:0]              M_HTRANS,
   output logic                    M_HWRITE,
   output logic [2:0]              M_HSIZE,
   output logic [2:0]              M_HBURST,
   output logic [DataWidth-1:0]    M_HWDATA,
   input  logic [DataWidth-1:0]    M_HRDATA,
   input  logic                    M_HREADY,
   input  logic                    M_HRESP,
   output logic                    IRQ,
   output logic [ChannelCount-1:0] IRQ_VEC
);

   localparam int unsigned IdxW      = (ChannelCount > 1) ? $clog2(ChannelCount) : 1;
   localparam int unsigned BeatBytes = DataWidth / 8;

   // Control-port address phase
   logic       ap_valid_q, ap_write_q;
   logic [8:0] ap_addr_q;
   logic       ap_is_ch, ctl_wr;
   logic [IdxW-1:0] ap_idx;
   logic [31:0] wdata, rd_word;

   // Channel registers
   logic [AddressWidth-1:0] src_q [ChannelCount];
   logic [AddressWidth-1:0] src_d [ChannelCount];
   logic [AddressWidth-1:0] dst_q [ChannelCount];
   logic [AddressWidth-1:0] dst_d [ChannelCount];
   logic [LenWidth-1:0]     len_q [ChannelCount];
   logic [LenWidth-1:0]     len_d [ChannelCount];
   ch_flags_t               fl_q  [ChannelCount];
   ch_flags_t               fl_d  [ChannelCount];
   logic [ChannelCount-1:0] irq_vec_d;

   // Manager sequencer
   dma_state_e              state_q, state_d;
   logic [IdxW-1:0]         cur_q;
   logic [DataWidth-1:0]    buf_q;
   logic [ChannelCount-1:0] req, gnt_oh;
   logic [IdxW-1:0]         gnt_idx;
   logic                    gnt_valid, grant_now, beat_ok, beat_err, active;

   logic unused_ok;
   assign unused_ok = ^{S_HTRANS[0], S_HADDR, S_HWDATA};

   assign S_HREADYout = 1'b1;
   assign S_HRESP     = 1'b0;
   assign M_HBURST    = HBURST_SINGLE;
   assign M_HSIZE     = 3'($clog2(BeatBytes));

   assign wdata    = S_HWDATA[31:0];
   assign ap_idx   = ap_addr_q[4 +: IdxW];
   assign ap_is_ch = !ap_addr_q[8] && ({1'b0, ap_addr_q[7:4]} < 5'(ChannelCount));
   assign ctl_wr   = ap_valid_q && ap_write_q && ap_is_ch;

   assign grant_now = (state_q == ST_IDLE) && gnt_valid;
   assign beat_ok   = (state_q == ST_WR_D) && M_HREADY && !M_HRESP;
   assign beat_err  = ((state_q == ST_RD_D) || (state_q == ST_WR_D)) && M_HREADY && M_HRESP;

   // Capture the control-port address phase; only word accesses are accepted
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         ap_valid_q <= 1'b0;
         ap_write_q <= 1'b0;
         ap_addr_q  <= '0;
      end else begin
         ap_valid_q <= S_HSEL && S_HREADYin && S_HTRANS[1] && (S_HSIZE == HSIZE_WORD);
         ap_write_q <= S_HWRITE;
         ap_addr_q  <= S_HADDR[8:0];
      end
   end

   // Read-data mux driven in the data phase
   always_comb begin
      rd_word = '0;
      if (ap_valid_q && !ap_write_q) begin
         if (ap_addr_q == ADDR_STATUS) begin
            rd_word = 32'(IRQ_VEC);
         end else if (ap_is_ch) begin
            case (ap_addr_q[3:0])
               OFF_SRC:  rd_word = 32'(src_q[ap_idx]);
               OFF_DST:  rd_word = 32'(dst_q[ap_idx]);
               OFF_LEN:  rd_word = 32'(len_q[ap_idx]);
               OFF_CTRL: rd_word = {21'b0, fl_q[ap_idx].err, fl_q[ap_idx].done,
                                    fl_q[ap_idx].busy, 4'b0, fl_q[ap_idx].ie,
                                    fl_q[ap_idx].dst_inc, fl_q[ap_idx].src_inc,
                                    fl_q[ap_idx].en};
               default:  rd_word = '0;
            endcase
         end
      end
   end
   assign S_HRDATA = DataWidth'(rd_word);

   // Busy channels request the manager port
   always_comb begin
      req = '0;
      for (int c = 0; c < ChannelCount; c++) req[c] = fl_q[c].busy;
   end

   dma_rr_arbiter #(
      .N    (ChannelCount),
      .IdxW (IdxW)
   ) u_arb (
      .req   (req),
      .last  (cur_q),
      .gnt   (gnt_oh),
      .idx   (gnt_idx),
      .valid (gnt_valid)
   );

   // Channel register next state: control writes first, manager updates override
   always_comb begin
      active    = 1'b0;
      irq_vec_d = '0;
      for (int c = 0; c < ChannelCount; c++) begin
         src_d[c] = src_q[c];
         dst_d[c] = dst_q[c];
         len_d[c] = len_q[c];
         fl_d[c]  = fl_q[c];
      end
      for (int c = 0; c < ChannelCount; c++) begin
         active = ((state_q != ST_IDLE) && (cur_q == IdxW'(c))) || (grant_now && gnt_oh[c]);
         if (ctl_wr && (ap_idx == IdxW'(c))) begin
            case (ap_addr_q[3:0])
               OFF_SRC: if (!fl_q[c].busy) src_d[c] = AddressWidth'(wdata);
               OFF_DST: if (!fl_q[c].busy) dst_d[c] = AddressWidth'(wdata);
               OFF_LEN: if (!fl_q[c].busy) len_d[c] = LenWidth'(wdata);
               OFF_CTRL: begin
                  fl_d[c].done    = 1'b0;
                  fl_d[c].err     = 1'b0;
                  fl_d[c].src_inc = wdata[CTRL_SRC_INC];
                  fl_d[c].dst_inc = wdata[CTRL_DST_INC];
                  fl_d[c].ie      = wdata[CTRL_IE];
                  if (wdata[CTRL_EN] && !fl_q[c].en) begin
                     if (len_q[c] == '0) begin
                        fl_d[c].done = 1'b1;
                     end else begin
                        fl_d[c].en   = 1'b1;
                        fl_d[c].busy = 1'b1;
                     end
                  end else if (!wdata[CTRL_EN]) begin
                     // An in-flight beat finishes before the abort takes effect
                     fl_d[c].en = 1'b0;
                     if (!active) fl_d[c].busy = 1'b0;
                  end
               end
               default: ;
            endcase
         end
         if (cur_q == IdxW'(c)) begin
            if (beat_ok) begin
               if (fl_q[c].src_inc) src_d[c] = src_q[c] + AddressWidth'(BeatBytes);
               if (fl_q[c].dst_inc) dst_d[c] = dst_q[c] + AddressWidth'(BeatBytes);
               len_d[c] = len_q[c] - LenWidth'(1);
               if (len_q[c] == LenWidth'(1)) begin
                  fl_d[c].busy = 1'b0;
                  fl_d[c].en   = 1'b0;
                  fl_d[c].done = 1'b1;
               end else if (!fl_d[c].en) begin
                  fl_d[c].busy = 1'b0;
               end
            end else if (beat_err) begin
               fl_d[c].err  = 1'b1;
               fl_d[c].busy = 1'b0;
               fl_d[c].en   = 1'b0;
            end
         end
         irq_vec_d[c] = fl_d[c].ie & (fl_d[c].done | fl_d[c].err);
      end
   end

   // Channel registers and interrupt outputs
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         for (int c = 0; c < ChannelCount; c++) begin
            src_q[c] <= '0;
            dst_q[c] <= '0;
            len_q[c] <= '0;
            fl_q[c]  <= '0;
         end
         IRQ_VEC <= '0;
         IRQ     <= 1'b0;
      end else begin
         for (int c = 0; c < ChannelCount; c++) begin
            src_q[c] <= src_d[c];
            dst_q[c] <= dst_d[c];
            len_q[c] <= len_d[c];
            fl_q[c]  <= fl_d[c];
         end
         IRQ_VEC <= irq_vec_d;
         IRQ     <= |irq_vec_d;
      end
   end

   // Sequencer state, granted channel and the one-word data buffer
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= ST_IDLE;
         cur_q   <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         if (grant_now) cur_q <= gnt_idx;
         if ((state_q == ST_RD_D) && M_HREADY && !M_HRESP) buf_q <= M_HRDATA;
      end
   end

   // Sequencer next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (gnt_valid) state_d = ST_RD_A;
         ST_RD_A: if (M_HREADY)  state_d = ST_RD_D;
         ST_RD_D: if (M_HREADY)  state_d = M_HRESP ? ST_IDLE : ST_WR_A;
         ST_WR_A: if (M_HREADY)  state_d = ST_WR_D;
         ST_WR_D: if (M_HREADY)  state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   // Manager-port outputs decoded from the current state
   always_comb begin
      M_HTRANS = HTRANS_IDLE;
      M_HADDR  = '0;
      M_HWRITE = 1'b0;
      M_HWDATA = '0;
      case (state_q)
         ST_RD_A: begin
            M_HTRANS = HTRANS_NONSEQ;
            M_HADDR  = src_q[cur_q];
         end
         ST_WR_A: begin
            M_HTRANS = HTRANS_NONSEQ;
            M_HADDR  = dst_q[cur_q];
            M_HWRITE = 1'b1;
         end
         ST_WR_D: M_HWDATA = buf_q;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dma_ahb_multichannel.sv
// Directed bench for dma_ahb_multichannel with a zero-wait AHB memory model.
module tb_dma_ahb_multichannel;

   localparam int unsigned NCH = 4;

   logic        HCLK, HRESETn;
   logic        S_HSEL, S_HWRITE, S_HREADYin;
   logic [31:0] S_HADDR, S_HWDATA, S_HRDATA;
   logic [1:0]  S_HTRANS;
   logic [2:0]  S_HSIZE;
   logic        S_HREADYout, S_HRESP;
   logic [31:0] M_HADDR, M_HWDATA, M_HRDATA;
   logic [1:0]  M_HTRANS;
   logic        M_HWRITE, M_HREADY, M_HRESP;
   logic [2:0]  M_HSIZE, M_HBURST;
   logic        IRQ;
   logic [NCH-1:0] IRQ_VEC;

   int total = 0;
   int bad   = 0;

   dma_ahb_multichannel #(
      .ChannelCount (NCH), .AddressWidth (32), .DataWidth (32), .LenWidth (16)
   ) dut (
      .HCLK (HCLK), .HRESETn (HRESETn),
      .S_HSEL (S_HSEL), .S_HADDR (S_HADDR), .S_HTRANS (S_HTRANS), .S_HWRITE (S_HWRITE),
      .S_HSIZE (S_HSIZE), .S_HWDATA (S_HWDATA), .S_HREADYin (S_HREADYin),
      .S_HRDATA (S_HRDATA), .S_HREADYout (S_HREADYout), .S_HRESP (S_HRESP),
      .M_HADDR (M_HADDR), .M_HTRANS (M_HTRANS), .M_HWRITE (M_HWRITE), .M_HSIZE (M_HSIZE),
      .M_HBURST (M_HBURST), .M_HWDATA (M_HWDATA), .M_HRDATA (M_HRDATA),
      .M_HREADY (M_HREADY), .M_HRESP (M_HRESP), .IRQ (IRQ), .IRQ_VEC (IRQ_VEC)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   // Memory model: word at address a holds 0xA0 + (a-0x1000)/4
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hA0 + ((a - 32'h1000) >> 2);
   endfunction

   logic        dp_valid, dp_write, dp_err;
   logic [31:0] dp_addr;
   logic [31:0] rd_log[$];
   logic [31:0] wr_addr_log[$];
   logic [31:0] wr_data_log[$];
   int          trans_cnt;
   int          err_at = -1;

   assign M_HRDATA = (dp_valid && !dp_write) ? mem_word(dp_addr) : 32'h0;
   assign M_HRESP  = dp_valid && dp_err;

   // Manager-side subordinate: logs reads at address phase and writes at data phase
   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dp_valid <= 1'b0;
         dp_write <= 1'b0;
         dp_err   <= 1'b0;
         dp_addr  <= '0;
      end else begin
         if (M_HTRANS != 2'b00) trans_cnt <= trans_cnt + 1;
         if (M_HREADY) begin
            if (dp_valid && dp_write && !dp_err) begin
               wr_addr_log.push_back(dp_addr);
               wr_data_log.push_back(M_HWDATA);
            end
            dp_valid <= M_HTRANS[1];
            dp_write <= M_HWRITE;
            dp_addr  <= M_HADDR;
            if (M_HTRANS[1] && !M_HWRITE) begin
               dp_err <= (rd_log.size() + 1 == err_at);
               rd_log.push_back(M_HADDR);
            end else begin
               dp_err <= 1'b0;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      S_HSEL = 1'b1; S_HADDR = a; S_HTRANS = 2'b10; S_HWRITE = 1'b1; S_HSIZE = 3'b010;
      @(posedge HCLK); #1;
      S_HSEL = 1'b0; S_HTRANS = 2'b00; S_HWRITE = 1'b0; S_HWDATA = d;
      @(posedge HCLK); #1;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      S_HSEL = 1'b1; S_HADDR = a; S_HTRANS = 2'b10; S_HWRITE = 1'b0; S_HSIZE = 3'b010;
      @(posedge HCLK); #1;
      S_HSEL = 1'b0; S_HTRANS = 2'b00;
      d = S_HRDATA;
      @(posedge HCLK); #1;
   endtask

   task automatic check_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] d;
      bus_read(a, d);
      check(name, d, exp);
   endtask

   task automatic wait_irq(input string name, input logic [NCH-1:0] mask);
      bit hit = 1'b0;
      for (int i = 0; i < 300 && !hit; i++) begin
         @(posedge HCLK); #1;
         if ((IRQ_VEC & mask) == mask) hit = 1'b1;
      end
      total++;
      if (!hit) begin
         bad++;
         $display("FAIL %s: irq_vec %b never covered %b", name, IRQ_VEC, mask);
      end
   endtask

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[12];

   initial begin
      logic [31:0] rd;
      int rbase, wbase, tbase;
      bit  hit;
      logic [31:0] exp_rd[6];

      vecs[0]  = '{1'b1, 32'h020, 32'hDEADBEEF, 32'h0};
      vecs[1]  = '{1'b0, 32'h020, 32'h0,        32'hDEADBEEF};
      vecs[2]  = '{1'b1, 32'h024, 32'h12345678, 32'h0};
      vecs[3]  = '{1'b0, 32'h024, 32'h0,        32'h12345678};
      vecs[4]  = '{1'b1, 32'h028, 32'h0001ABCD, 32'h0};
      vecs[5]  = '{1'b0, 32'h028, 32'h0,        32'h0000ABCD};
      vecs[6]  = '{1'b1, 32'h02C, 32'h0000000E, 32'h0};
      vecs[7]  = '{1'b0, 32'h02C, 32'h0,        32'h0000000E};
      vecs[8]  = '{1'b1, 32'h040, 32'h00000055, 32'h0};
      vecs[9]  = '{1'b0, 32'h040, 32'h0,        32'h0};
      vecs[10] = '{1'b0, 32'h104, 32'h0,        32'h0};
      vecs[11] = '{1'b0, 32'h030, 32'h0,        32'h0};

      HRESETn = 1'b0; S_HSEL = 1'b0; S_HADDR = '0; S_HTRANS = 2'b00; S_HWRITE = 1'b0;
      S_HSIZE = 3'b010; S_HWDATA = '0; S_HREADYin = 1'b1; M_HREADY = 1'b1; trans_cnt = 0;
      repeat (3) @(posedge HCLK);
      @(negedge HRESETn or negedge HCLK);
      HRESETn = 1'b1;
      @(posedge HCLK); #1;

      // Reset state
      check("rst_htrans", 32'(M_HTRANS), 32'h0);
      check("rst_haddr", M_HADDR, 32'h0);
      check("rst_irq", 32'(IRQ), 32'h0);
      check("rst_ready", 32'({S_HREADYout, S_HRESP}), 32'h2);
      check_rd("rst_ctrl0", 32'h00C, 32'h0);
      check_rd("rst_status", 32'h100, 32'h0);

      // Register access table
      for (int i = 0; i < 12; i++) begin
         if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
         else check_rd($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
      end

      // Basic 4-beat copy on ch0
      wbase = wr_addr_log.size();
      bus_write(32'h000, 32'h1000);
      bus_write(32'h004, 32'h2000);
      bus_write(32'h008, 32'd4);
      bus_write(32'h00C, 32'hF);
      wait_irq("t1_irq_wait", 4'b0001);
      check("t1_wr_count", 32'(wr_addr_log.size() - wbase), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t1_wa%0d", i), wr_addr_log[wbase + i], 32'h2000 + 32'(4 * i));
         check($sformatf("t1_wd%0d", i), wr_data_log[wbase + i], 32'hA0 + 32'(i));
      end
      check("t1_irq", 32'(IRQ), 32'h1);
      check_rd("t1_ctrl", 32'h00C, 32'h20E);
      check_rd("t1_len", 32'h008, 32'h0);
      check_rd("t1_src", 32'h000, 32'h1010);
      check_rd("t1_dst", 32'h004, 32'h2010);
      check_rd("t1_status", 32'h100, 32'h1);
      bus_write(32'h00C, 32'h0);
      check("t1_irq_clr", 32'(IRQ), 32'h0);

      // Two channels interleave one beat at a time
      rbase = rd_log.size();
      bus_write(32'h000, 32'h1100); bus_write(32'h004, 32'h2100); bus_write(32'h008, 32'd3);
      bus_write(32'h010, 32'h3000); bus_write(32'h014, 32'h3100); bus_write(32'h018, 32'd3);
      bus_write(32'h00C, 32'hF);
      bus_write(32'h01C, 32'hF);
      wait_irq("t2_irq_wait", 4'b0011);
      exp_rd = '{32'h1100, 32'h3000, 32'h1104, 32'h3004, 32'h1108, 32'h3008};
      check("t2_rd_count", 32'(rd_log.size() - rbase), 32'd6);
      for (int i = 0; i < 6; i++)
         if (rbase + i < rd_log.size())
            check($sformatf("t2_order%0d", i), rd_log[rbase + i], exp_rd[i]);
      check_rd("t2_status", 32'h100, 32'h3);
      bus_write(32'h00C, 32'h0);
      bus_write(32'h01C, 32'h0);

      // Fixed source address, incrementing destination
      rbase = rd_log.size();
      wbase = wr_addr_log.size();
      bus_write(32'h000, 32'h1200); bus_write(32'h004, 32'h2200); bus_write(32'h008, 32'd5);
      bus_write(32'h00C, 32'hD);
      wait_irq("t3_irq_wait", 4'b0001);
      check("t3_wr_count", 32'(wr_addr_log.size() - wbase), 32'd5);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t3_ra%0d", i), rd_log[rbase + i], 32'h1200);
         check($sformatf("t3_wa%0d", i), wr_addr_log[wbase + i], 32'h2200 + 32'(4 * i));
      end
      check_rd("t3_src", 32'h000, 32'h1200);
      bus_write(32'h00C, 32'h0);

      // Read error on the second beat
      rbase = rd_log.size();
      wbase = wr_addr_log.size();
      err_at = rbase + 2;
      bus_write(32'h000, 32'h1300); bus_write(32'h004, 32'h2300); bus_write(32'h008, 32'd4);
      bus_write(32'h00C, 32'hF);
      wait_irq("t4_irq_wait", 4'b0001);
      repeat (10) @(posedge HCLK); #1;
      err_at = -1;
      check_rd("t4_ctrl", 32'h00C, 32'h40E);
      check_rd("t4_len", 32'h008, 32'd3);
      check_rd("t4_src", 32'h000, 32'h1304);
      check("t4_wr_count", 32'(wr_addr_log.size() - wbase), 32'd1);
      check("t4_rd_count", 32'(rd_log.size() - rbase), 32'd2);
      bus_write(32'h00C, 32'h0);
      check("t4_irq_clr", 32'(IRQ), 32'h0);

      // Zero-length enable completes without bus traffic
      bus_write(32'h028, 32'h0);
      tbase = trans_cnt;
      bus_write(32'h02C, 32'hF);
      check("t5_irq", 32'(IRQ_VEC), 32'h4);
      repeat (8) @(posedge HCLK); #1;
      check_rd("t5_ctrl", 32'h02C, 32'h20E);
      check("t5_no_trans", 32'(trans_cnt - tbase), 32'd0);

      // Asynchronous reset in the middle of a write address phase
      bus_write(32'h010, 32'h1400); bus_write(32'h014, 32'h2400); bus_write(32'h018, 32'd2);
      bus_write(32'h01C, 32'hF);
      hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
         if (M_HTRANS == 2'b10 && M_HWRITE) hit = 1'b1;
         else begin @(posedge HCLK); #1; end
      end
      check("t6_reach_wr_a", 32'(hit), 32'h1);
      check("t6_wr_a_addr", M_HADDR, 32'h2400);
      #2;
      HRESETn = 1'b0;
      #1;
      check("t6_htrans", 32'(M_HTRANS), 32'h0);
      check("t6_haddr", M_HADDR, 32'h0);
      check("t6_hwrite", 32'(M_HWRITE), 32'h0);
      check("t6_irq", 32'({IRQ_VEC, IRQ}), 32'h0);
      repeat (2) @(posedge HCLK);
      @(negedge HCLK);
      HRESETn = 1'b1;
      @(posedge HCLK); #1;
      check_rd("t6_src1", 32'h010, 32'h0);
      check_rd("t6_dst1", 32'h014, 32'h0);
      check_rd("t6_len1", 32'h018, 32'h0);
      check_rd("t6_ctrl1", 32'h01C, 32'h0);
      check_rd("t6_ctrl2", 32'h02C, 32'h0);
      check_rd("t6_status", 32'h100, 32'h0);
      check("t6_idle", 32'(M_HTRANS), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dma_ahb_multichannel.md
Name: dma_ahb_multichannel

Overview:
- Parametrised successor to the single-channel AHB DMA engine.
- Provides ChannelCount independent memory-to-memory channels, each with its own registers.
- Registers are programmed over an AHB-lite subordinate control port; data moves over one AHB-lite manager port.
- Channels are arbitrated round-robin, one beat per grant, and raise per-channel done/error interrupts. The block sits between the Renode-driven control bus and the system data bus.

Parameters:
- ChannelCount, 4, number of channels (1..8).
- AddressWidth, 32, width of HADDR on both ports.
- DataWidth, 32, width of HWDATA/HRDATA on both ports (32 or 64).
- LenWidth, 16, width of the per-channel beat counter.

Ports:
- HCLK  in  1  single clock for the whole block.
- HRESETn  in  1  asynchronous active-low reset.
- S_HSEL  in  1  control-port select.
- S_HADDR  in  AddressWidth  control address; bits [8:0] are decoded.
- S_HTRANS  in  2  transfer type.
- S_HWRITE  in  1  write strobe.
- S_HSIZE  in  3  size; only word accesses are supported.
- S_HWDATA  in  DataWidth  write data (bits [31:0] are used).
- S_HREADYin  in  1  bus ready.
- S_HRDATA  out  DataWidth  read data.
- S_HREADYout  out  1  always 1 (zero wait states).
- S_HRESP  out  1  always 0 (OKAY).
- M_HADDR  out  AddressWidth  manager address.
- M_HTRANS  out  2  IDLE or NONSEQ only.
- M_HWRITE  out  1  manager write.
- M_HSIZE  out  3  log2(DataWidth/8).
- M_HBURST  out  3  always SINGLE.
- M_HWDATA  out  DataWidth  write data.
- M_HRDATA  in  DataWidth  read data.
- M_HREADY  in  1  manager ready.
- M_HRESP  in  1  manager error.
- IRQ  out  1  OR of all channel interrupts.
- IRQ_VEC  out  ChannelCount  per-channel interrupt.

Behaviour:
- Register map: channel c occupies base 0x10*c.
  - +0x0 SRC.
  - +0x4 DST.
  - +0x8 LEN (beats, LenWidth bits).
  - +0xC CTRL, write fields: bit0 EN, bit1 SRC_INC, bit2 DST_INC, bit3 IE. Read adds bit8 BUSY, bit9 DONE, bit10 ERR.
  - 0x100 STATUS (read-only): bit c = IRQ_VEC[c].
  - Unmapped addresses read 0; writes to them are ignored.
- Control port:
  - Address phase is registered when S_HSEL & S_HREADYin & S_HTRANS[1]. The write is applied in the following data phase.
  - Read data is driven in the data phase from the registered address.
- CTRL write semantics:
  - Writing CTRL clears DONE and ERR.
  - EN 0->1 sets BUSY. If LEN==0, BUSY is not set and DONE is set on the next cycle, with no bus traffic.
  - Writes to SRC, DST or LEN while BUSY are ignored.
  - Writing EN=0 while BUSY aborts after the in-flight beat completes (never mid-beat). BUSY then clears; DONE stays 0.
- Manager FSM states: IDLE, RD_A, RD_D, WR_A, WR_D.
  - IDLE: pick the next BUSY channel round-robin, starting after the last granted channel; latch its index, then go to RD_A.
  - RD_A: drive NONSEQ, HWRITE=0, HADDR=SRC. Advance on M_HREADY.
  - RD_D: wait for M_HREADY, capture M_HRDATA into a 1-word buffer, go to WR_A. HTRANS is IDLE.
  - WR_A: drive NONSEQ, HWRITE=1, HADDR=DST. Advance on M_HREADY.
  - WR_D: drive the buffer on M_HWDATA. On M_HREADY:
    - SRC += DataWidth/8 if SRC_INC; DST += DataWidth/8 if DST_INC.
    - LEN -= 1. If LEN reaches 0: clear BUSY and EN, set DONE.
    - Return to IDLE.
  - Each beat costs at least 4 cycles plus 1 arbitration cycle.
- Error: M_HRESP=1 with M_HREADY=1 in RD_D or WR_D sets ERR, clears BUSY and EN, and leaves LEN/SRC/DST unchanged. Write data is not issued after a read error.
- Addresses wrap modulo 2^AddressWidth. Misaligned SRC/DST are not checked; low bits pass through unchanged.
- Interrupts: IRQ_VEC[c] = IE & (DONE | ERR); IRQ = |IRQ_VEC.
- Simultaneous control write and manager update on the same channel: the manager update wins for LEN/SRC/DST. The CTRL EN=0 abort is honoured at the next beat boundary.
- Reset (async, any state): all registers 0, FSM to IDLE, M_HTRANS=IDLE, M_HADDR=0, M_HWRITE=0, M_HWDATA=0, S_HRDATA=0, IRQ/IRQ_VEC=0, round-robin pointer 0.

Decomposition:
- Shared package dma_pkg holds:
  - the state enum;
  - HTRANS/HBURST/HSIZE constants;
  - register offsets and CTRL bit positions;
  - the channel-register struct.
- One sub-module, dma_rr_arbiter: takes the ChannelCount request vector and the last grant; outputs a one-hot grant and an index.

Test Plan:
- Ch0 SRC=0x1000, DST=0x2000, LEN=4, CTRL=0xF; memory holds 0xA0..0xA3 -> 0x2000..0x200C receive those words, DONE=1, IRQ=1. A CTRL write of 0 clears IRQ.
- Ch0 and ch1 both enabled with LEN=3 -> manager beats alternate 0,1,0,1,0,1. Both reach DONE; STATUS=0x3.
- SRC_INC=0 (FIFO-style source), LEN=5 -> five reads from the same address, DST advances by 4 each beat.
- M_HRESP error on the second read of LEN=4 -> ERR=1, BUSY=0, LEN reads back 3, no write issued for that beat.
- LEN=0 with EN=1 -> DONE the next cycle, M_HTRANS stays IDLE throughout.
- HRESETn asserted mid WR_A -> outputs go to reset values immediately (asynchronously), all registers read 0 afterwards.
